// File: rtl/mrd_mem_pp_buf.sv
// Ping-pong sample buffer: two banked slots that are filled by the sink, processed by the radix engine and drained in order.
// Build option: define MRD_MEM_PP_DROP_CNT_EN to enable the saturating dropped-frame counter on drop_cnt.
module mrd_mem_pp_buf #(
    parameter int DW    = 18,
    parameter int NBANK = 7,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic [11:0]   in_dftpts,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          proc_req,
    output logic [11:0]   proc_dftpts,
    input  logic          proc_rd_en,
    input  logic [2:0]    proc_rd_bank,
    input  logic [AW-1:0] proc_rd_addr,
    output logic [DW-1:0] proc_rd_real,
    output logic [DW-1:0] proc_rd_imag,
    output logic          proc_rd_valid,
    input  logic          proc_wr_en,
    input  logic [2:0]    proc_wr_bank,
    input  logic [AW-1:0] proc_wr_addr,
    input  logic [DW-1:0] proc_wr_real,
    input  logic [DW-1:0] proc_wr_imag,
    input  logic          proc_done,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic [15:0]   drop_cnt
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [31:0] CAP_U     = 32'(NBANK * DEPTH);
    localparam logic [2:0]  LAST_BANK = 3'(NBANK - 1);
    localparam logic [3:0]  NBANK4    = 4'(NBANK);

    typedef enum logic [2:0] {S_FREE, S_FILL, S_READY, S_PROC, S_DRAIN} slot_t;
    typedef enum logic [1:0] {R_IDLE, R_PROC, R_DRAIN} rstate_t;

    slot_t           st [2];
    slot_t           st_nxt [2];
    rstate_t         rstate, rstate_nxt;
    logic            r_slot, r_slot_nxt;
    logic            old_slot, old_slot_nxt;
    logic [11:0]     len [2];

    logic [2:0]      wr_bank, dr_bank, rd_bank, sink_bank;
    logic [AW-1:0]   wr_addr, dr_addr, rd_addr, sink_addr;
    logic [11:0]     wr_cnt, dr_cnt;

    logic [2*DW-1:0] mem [2][NBANK][DEPTH];
    logic [2*DW-1:0] rd_data;
    logic            p1_valid, p1_sop, p1_eop;

    logic sop_v, len_ok, fill_any, fill_slot, free_any, free_slot;
    logic sop_fill, sop_new, sop_take, tgt, cont, sink_we, sink_slot, sink_last;
    logic dr0, dr1, rdy0, rdy1, drain_sel, ready_sel;
    logic eng_we, eng_rd, dr_re, dr_last, rd_en;

    // Sink decode: a sop restarts an in-progress fill, otherwise claims the lowest free slot.
    assign sop_v     = in_valid & in_sop;
    assign len_ok    = (in_dftpts != '0) && (32'(in_dftpts) <= CAP_U);
    assign fill_any  = (st[0] == S_FILL) || (st[1] == S_FILL);
    assign fill_slot = (st[0] == S_FILL) ? 1'b0 : 1'b1;
    assign free_any  = (st[0] == S_FREE) || (st[1] == S_FREE);
    assign free_slot = (st[0] == S_FREE) ? 1'b0 : 1'b1;
    assign sop_fill  = sop_v & len_ok & fill_any;
    assign sop_new   = sop_v & len_ok & ~fill_any & free_any;
    assign sop_take  = sop_fill | sop_new;
    assign tgt       = sop_fill ? fill_slot : free_slot;
    assign cont      = in_valid & ~in_sop & fill_any;
    assign sink_we   = sop_take | cont;
    assign sink_slot = sop_take ? tgt : fill_slot;
    assign sink_bank = sop_take ? 3'd0 : wr_bank;
    assign sink_addr = sop_take ? '0 : wr_addr;
    assign sink_last = sop_take ? (in_dftpts == 12'd1)
                                : ((wr_cnt + 12'd1) == len[fill_slot]);

    assign dr0       = (st[0] == S_DRAIN);
    assign dr1       = (st[1] == S_DRAIN);
    assign rdy0      = (st[0] == S_READY);
    assign rdy1      = (st[1] == S_READY);
    assign drain_sel = (dr0 & dr1) ? old_slot : dr1;
    assign ready_sel = (rdy0 & rdy1) ? old_slot : rdy1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0]    <= S_FREE;
            st[1]    <= S_FREE;
            rstate   <= R_IDLE;
            r_slot   <= 1'b0;
            old_slot <= 1'b0;
        end else begin
            st[0]    <= st_nxt[0];
            st[1]    <= st_nxt[1];
            rstate   <= rstate_nxt;
            r_slot   <= r_slot_nxt;
            old_slot <= old_slot_nxt;
        end
    end

    always_comb begin
        st_nxt[0]    = st[0];
        st_nxt[1]    = st[1];
        rstate_nxt   = rstate;
        r_slot_nxt   = r_slot;
        old_slot_nxt = old_slot;
        // A completing frame is younger than any frame already waiting in the other slot.
        if (sink_we && sink_last) begin
            st_nxt[sink_slot] = S_READY;
            old_slot_nxt = (st[~sink_slot] inside {S_READY, S_PROC, S_DRAIN}) ? ~sink_slot : sink_slot;
        end else if (sop_take) begin
            st_nxt[tgt] = S_FILL;
        end
        case (rstate)
            R_IDLE: begin
                if (dr0 | dr1) begin
                    rstate_nxt = R_DRAIN;
                    r_slot_nxt = drain_sel;
                end else if (rdy0 | rdy1) begin
                    rstate_nxt        = R_PROC;
                    r_slot_nxt        = ready_sel;
                    st_nxt[ready_sel] = S_PROC;
                end
            end
            R_PROC: begin
                if (proc_done) begin
                    st_nxt[r_slot] = S_DRAIN;
                    rstate_nxt     = R_IDLE;
                end
            end
            R_DRAIN: begin
                if (dr_last) begin
                    st_nxt[r_slot] = S_FREE;
                    rstate_nxt     = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        proc_req    = (rstate == R_PROC);
        proc_dftpts = proc_req ? len[r_slot] : '0;
        eng_we      = proc_req & proc_wr_en & ({1'b0, proc_wr_bank} < NBANK4);
        eng_rd      = proc_req & proc_rd_en;
        dr_re       = (rstate == R_DRAIN);
        dr_last     = dr_re & (dr_cnt == (len[r_slot] - 12'd1));
        rd_en       = dr_re | (eng_rd & ({1'b0, proc_rd_bank} < NBANK4));
        rd_bank     = dr_re ? dr_bank : proc_rd_bank;
        rd_addr     = dr_re ? dr_addr : proc_rd_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= '0;
            wr_addr <= '0;
            wr_cnt  <= '0;
            dr_bank <= '0;
            dr_addr <= '0;
            dr_cnt  <= '0;
            len[0]  <= '0;
            len[1]  <= '0;
        end else begin
            if (sink_we) begin
                wr_bank <= (sink_bank == LAST_BANK) ? 3'd0 : sink_bank + 3'd1;
                wr_addr <= (sink_bank == LAST_BANK) ? sink_addr + AW'(1) : sink_addr;
                wr_cnt  <= sop_take ? 12'd1 : wr_cnt + 12'd1;
            end
            if (sop_take)
                len[tgt] <= in_dftpts;
            if (dr_re) begin
                dr_bank <= (dr_bank == LAST_BANK) ? 3'd0 : dr_bank + 3'd1;
                dr_addr <= (dr_bank == LAST_BANK) ? dr_addr + AW'(1) : dr_addr;
                dr_cnt  <= dr_cnt + 12'd1;
            end else begin
                dr_bank <= '0;
                dr_addr <= '0;
                dr_cnt  <= '0;
            end
        end
    end

    // Sink and engine always target different slots, so both writes land in the same cycle.
    always_ff @(posedge clk) begin
        if (sink_we)
            mem[sink_slot][sink_bank][sink_addr] <= {in_real, in_imag};
        if (eng_we)
            mem[r_slot][proc_wr_bank][proc_wr_addr] <= {proc_wr_real, proc_wr_imag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            proc_rd_valid <= 1'b0;
            p1_valid      <= 1'b0;
            p1_sop        <= 1'b0;
            p1_eop        <= 1'b0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_real      <= '0;
            out_imag      <= '0;
        end else begin
            if (rd_en)
                rd_data <= mem[r_slot][rd_bank][rd_addr];
            proc_rd_valid <= eng_rd;
            p1_valid      <= dr_re;
            p1_sop        <= dr_re & (dr_cnt == '0);
            p1_eop        <= dr_last;
            out_valid     <= p1_valid;
            out_sop       <= p1_sop;
            out_eop       <= p1_eop;
            if (p1_valid) begin
                out_real <= rd_data[2*DW-1:DW];
                out_imag <= rd_data[DW-1:0];
            end
        end
    end

    assign proc_rd_real = rd_data[2*DW-1:DW];
    assign proc_rd_imag = rd_data[DW-1:0];

`ifdef MRD_MEM_PP_DROP_CNT_EN
    logic        drop_evt;
    logic [15:0] drop_q;
    assign drop_evt = sop_v & ~sop_take;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (drop_evt && (drop_q != '1))
            drop_q <= drop_q + 16'd1;
    end
    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
